// File: rtl/branch_resolve_unit.sv
// Branch decision block: evaluates the condition code against the carry flag or rs_val,
// issues a one-cycle redirect (and link write for BL), then holds a counted flush.
module branch_resolve_unit #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flag_we,
   input  logic              alu_carry,
   input  logic              br_valid,
   input  logic [2:0]        br_cond,
   input  logic [ADDR_W-1:0] br_target,
   input  logic [ADDR_W-1:0] pc_plus1,
   input  logic [DATA_W-1:0] rs_val,
   input  logic              stall,
   output logic              redirect,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              link_we,
   output logic [ADDR_W-1:0] link_addr,
   output logic              flush,
   output logic              busy,
   output logic              carry_q
);

   localparam int unsigned CNT_W = 4;

   localparam logic [2:0] COND_BR   = 3'b000;
   localparam logic [2:0] COND_NOP  = 3'b001;
   localparam logic [2:0] COND_BCY  = 3'b010;
   localparam logic [2:0] COND_BNCY = 3'b011;
   localparam logic [2:0] COND_BZ   = 3'b100;
   localparam logic [2:0] COND_BNZ  = 3'b101;
   localparam logic [2:0] COND_BLTZ = 3'b110;
   localparam logic [2:0] COND_BL   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FLUSH = 2'b01
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                carry_flag_q, carry_flag_d;
   logic                redirect_q, redirect_d;
   logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
   logic                link_we_q, link_we_d;
   logic [ADDR_W-1:0]   link_addr_q, link_addr_d;
   logic                flush_q, flush_d;
   logic                busy_q, busy_d;

   logic                c_eff;
   logic                br_taken;
   logic                br_accept;

   // Condition evaluation; a same-cycle flag write is forwarded into the decision
   always_comb begin
      c_eff    = flag_we ? alu_carry : carry_flag_q;
      br_taken = 1'b0;
      case (br_cond)
         COND_BR:   br_taken = 1'b1;
         COND_NOP:  br_taken = 1'b0;
         COND_BCY:  br_taken = c_eff;
         COND_BNCY: br_taken = ~c_eff;
         COND_BZ:   br_taken = (rs_val == '0);
         COND_BNZ:  br_taken = (rs_val != '0);
         COND_BLTZ: br_taken = rs_val[DATA_W-1];
         COND_BL:   br_taken = 1'b1;
         default:   br_taken = 1'b0;
      endcase
   end

   assign br_accept = (state_q == ST_IDLE) && br_valid && !stall;

   // Next-state and registered-output decode
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      carry_flag_d  = flag_we ? alu_carry : carry_flag_q;
      redirect_d    = 1'b0;
      link_we_d     = 1'b0;
      redirect_pc_d = redirect_pc_q;
      link_addr_d   = link_addr_q;
      flush_d       = flush_q;
      busy_d        = busy_q;

      case (state_q)
         ST_IDLE: begin
            flush_d = 1'b0;
            busy_d  = 1'b0;
            if (br_accept && br_taken) begin
               state_d       = ST_FLUSH;
               cnt_d         = CNT_W'(FLUSH_CYCLES);
               redirect_d    = 1'b1;
               redirect_pc_d = br_target;
               flush_d       = 1'b1;
               busy_d        = 1'b1;
               if (br_cond == COND_BL) begin
                  link_we_d   = 1'b1;
                  link_addr_d = pc_plus1;
               end
            end
         end
         ST_FLUSH: begin
            // Counter freezes under stall; leaving FLUSH on the 1 -> 0 step
            if (!stall) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  flush_d = 1'b0;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            flush_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         carry_flag_q  <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         link_we_q     <= 1'b0;
         link_addr_q   <= '0;
         flush_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         carry_flag_q  <= carry_flag_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         link_we_q     <= link_we_d;
         link_addr_q   <= link_addr_d;
         flush_q       <= flush_d;
         busy_q        <= busy_d;
      end
   end

   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign link_we     = link_we_q;
   assign link_addr   = link_addr_q;
   assign flush       = flush_q;
   assign busy        = busy_q;
   assign carry_q     = carry_flag_q;

endmodule
